// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ byte producers,
// with optional packet locking so a multi-byte message stays contiguous on the line.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter bit LOCK_PACKET  = 1'b1,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_start,
   input  logic                   tx_busy,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   timeout_err
);

   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = $clog2(BUSY_TIMEOUT);

   typedef enum logic [1:0] {ARB, SEND, WAIT_HI, WAIT_LO} state_t;

   state_t          state;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   owner;
   logic            lock;
   logic [CW-1:0]   cnt;
   logic [PW-1:0]   win_idx;
   logic            win_found;
   logic            accept;
   logic [7:0]      req_byte [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_byte
      assign req_byte[g] = req_data[8*g +: 8];
   end

   // A held lock pins the winner to its owner even when the owner is idle,
   // which stalls everyone else until the packet's last byte.
   always_comb begin
      int j;
      j         = 0;
      win_found = 1'b0;
      win_idx   = '0;
      if (lock) begin
         win_idx   = owner;
         win_found = req_valid[owner];
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!win_found && req_valid[j]) begin
               win_found = 1'b1;
               win_idx   = PW'(j);
            end
         end
      end
   end

   assign accept = (state == ARB) && !tx_busy && win_found;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[win_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ARB;
         tx_data     <= '0;
         tx_start    <= 1'b0;
         grant       <= '0;
         timeout_err <= 1'b0;
         rr_ptr      <= '0;
         owner       <= '0;
         lock        <= 1'b0;
         cnt         <= '0;
      end else begin
         tx_start    <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            ARB: begin
               if (accept) begin
                  tx_data  <= req_byte[win_idx];
                  tx_start <= 1'b1;
                  grant    <= req_ready;
                  state    <= SEND;
                  if (!lock)
                     rr_ptr <= (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
                  if (LOCK_PACKET && !req_last[win_idx]) begin
                     lock  <= 1'b1;
                     owner <= win_idx;
                  end else begin
                     lock  <= 1'b0;
                  end
               end
            end
            SEND: begin
               cnt   <= '0;
               state <= WAIT_HI;
            end
            WAIT_HI: begin
               // Stuck serializer: give up, drop the lock so others are not starved.
               if (tx_busy) begin
                  state <= WAIT_LO;
               end else if (cnt == CW'(BUSY_TIMEOUT-2)) begin
                  timeout_err <= 1'b1;
                  lock        <= 1'b0;
                  grant       <= '0;
                  state       <= ARB;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_LO: begin
               if (!tx_busy) begin
                  state <= ARB;
                  if (!lock) grant <= '0;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule
